// File: rtl/regfile_32x64.sv
// regfile_32x64: 32 x 64-bit register file with two combinational read
// ports, one synchronous write port, optional write-to-read forwarding,
// a hardwired-zero register and a count of committed writes.
module regfile_32x64 #(
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [63:0] wd,
  output logic [63:0] da,
  output logic [63:0] db,
  output logic [15:0] wr_cnt
);

  localparam logic [4:0] ZeroIdx   = 5'(ZERO_REG);
  localparam bit         BypassOn  = (BYPASS != 0);

  logic [63:0] r_mem [32];
  logic [15:0] r_wrCnt;
  logic        w_commit;
  logic        w_fwdA;
  logic        w_fwdB;
  logic [63:0] w_readA;
  logic [63:0] w_readB;

  // A write only commits when enabled and not aimed at the zero register;
  // during reset the flops are held clear, so a pending write is dropped.
  assign w_commit = we && (wa != ZeroIdx);

  // Forwarding is suppressed while reset is asserted so reads stay zero.
  assign w_fwdA = BypassOn && rst_n && w_commit && (wa == ra);
  assign w_fwdB = BypassOn && rst_n && w_commit && (wa == rb);

  // Storage array: asynchronous clear, then one write per rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= 64'h0;
      end
    end else if (w_commit) begin
      r_mem[wa] <= wd;
    end
  end

  // Committed-write counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrCnt <= 16'h0;
    end else if (w_commit) begin
      r_wrCnt <= r_wrCnt + 16'h1;
    end
  end

  // Read port A: stored value, optionally forwarded write data, forced to
  // zero for the zero register or while reset is asserted.
  always_comb begin
    w_readA = r_mem[ra];
    if (w_fwdA) begin
      w_readA = wd;
    end
    if ((ra == ZeroIdx) || !rst_n) begin
      w_readA = 64'h0;
    end
  end

  // Read port B: identical structure, fully independent of port A.
  always_comb begin
    w_readB = r_mem[rb];
    if (w_fwdB) begin
      w_readB = wd;
    end
    if ((rb == ZeroIdx) || !rst_n) begin
      w_readB = 64'h0;
    end
  end

  assign da     = w_readA;
  assign db     = w_readB;
  assign wr_cnt = r_wrCnt;

endmodule
